// File: rtl/sha256_w_schedule.sv
// ----------------------------------------------------------------------------
// sha256_w_schedule
//
// Expands one 512-bit padded SHA-256 message block into the 64-word message
// schedule W[0..63], stores it in an internal 64x32 register file and flags
// completion. The compression core then fetches words by address.
//
// Timing: a start event sampled at edge E0 loads W[0..15] at E1, computes
// W[16..63] on E2..E49, and raises regop_w_reg_rdy on E49.
//
// Ports:
//   clock             in   1    system clock, rising edge
//   reset             in   1    synchronous, active-high
//   local_go_sig      in   1    start request; only a 0->1 transition starts
//   pad_reg           in   512  padded block; [511:480] = W[0], [31:0] = W[15]
//   w_reg_read        in   1    read strobe for the register file
//   w_reg_addr        in   6    word index 0..63
//   regop_w_reg_rdy   out  1    registered; high once W[0..63] are complete
//   regop_w_reg_data  out  32   registered read data (1-cycle latency)
//
// Optional build macro:
//   W_SCHED_READ_GATE_EN - when defined, reads return data only while
//   regop_w_reg_rdy is high; a read while not ready returns 32'h0.
//
// Handshake: a start event is local_go_sig high this cycle and low the
// previous cycle. It is accepted in IDLE and DONE and ignored in LOAD/COMP.
// Reads have no ready: w_reg_read high at an edge always captures a word.
// ----------------------------------------------------------------------------
module sha256_w_schedule (
    input  logic         clock,
    input  logic         reset,
    input  logic         local_go_sig,
    input  logic [511:0] pad_reg,
    input  logic         w_reg_read,
    input  logic [5:0]   w_reg_addr,
    output logic         regop_w_reg_rdy,
    output logic [31:0]  regop_w_reg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        COMP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  state_dbg;   // current FSM state as plain bits for debug probing

    logic        go_prev;
    logic        start;
    logic [5:0]  t_cnt;
    logic [5:0]  t_next;
    logic        rdy_next;

    logic [31:0] w_mem [64];

    logic [5:0]  idx_m2;
    logic [5:0]  idx_m7;
    logic [5:0]  idx_m15;
    logic [5:0]  idx_m16;
    logic [31:0] w_new;
    logic [31:0] read_val;

    assign state_dbg = state;

    // Rising-edge qualification of the go request: a held level starts once.
    assign start = local_go_sig & ~go_prev;

    // ------------------------------------------------------------------------
    // SHA-256 small sigma functions
    // ------------------------------------------------------------------------
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        sigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        sigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // Tap indices wrap modulo 64; while in COMP t_cnt is 16..63 so all taps
    // point at words already written in this block.
    assign idx_m2  = t_cnt - 6'd2;
    assign idx_m7  = t_cnt - 6'd7;
    assign idx_m15 = t_cnt - 6'd15;
    assign idx_m16 = t_cnt - 6'd16;

    assign w_new = sigma1(w_mem[idx_m2]) + w_mem[idx_m7]
                 + sigma0(w_mem[idx_m15]) + w_mem[idx_m16];

    // ------------------------------------------------------------------------
    // FSM: next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        t_next     = t_cnt;
        rdy_next   = regop_w_reg_rdy;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                t_next     = 6'd16;
                state_next = COMP;
            end
            COMP: begin
                t_next = t_cnt + 6'd1;
                if (t_cnt == 6'd63) begin
                    // W[63] is written on this same edge, so the schedule is
                    // complete when rdy becomes visible.
                    state_next = DONE;
                    rdy_next   = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = LOAD;
                    rdy_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                rdy_next   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            t_cnt           <= 6'd0;
            regop_w_reg_rdy <= 1'b0;
            go_prev         <= 1'b0;
        end else begin
            state           <= state_next;
            t_cnt           <= t_next;
            regop_w_reg_rdy <= rdy_next;
            go_prev         <= local_go_sig;
        end
    end

    // ------------------------------------------------------------------------
    // Register file writes. Contents survive reset; a reset only stops any
    // in-flight computation from writing further words.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == LOAD) begin
                for (int i = 0; i < 16; i++) begin
                    w_mem[i] <= pad_reg[511 - 32*i -: 32];
                end
            end else if (state == COMP) begin
                w_mem[t_cnt] <= w_new;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read port: 1-cycle latency, output holds when no strobe
    // ------------------------------------------------------------------------
`ifdef W_SCHED_READ_GATE_EN
    assign read_val = regop_w_reg_rdy ? w_mem[w_reg_addr] : 32'h0;
`else
    assign read_val = w_mem[w_reg_addr];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            regop_w_reg_data <= 32'h0;
        end else if (w_reg_read) begin
            regop_w_reg_data <= read_val;
        end
    end

endmodule

// File: tb/tb_sha256_w_schedule.sv
// ----------------------------------------------------------------------------
// tb_sha256_w_schedule
//
// Directed bench for sha256_w_schedule. Expected schedule words come from an
// independent reference model written from the SHA-256 definition, plus the
// published "abc" constants. Read results flow through an expected queue.
// ----------------------------------------------------------------------------
module tb_sha256_w_schedule;

    logic         clock;
    logic         reset;
    logic         local_go_sig;
    logic [511:0] pad_reg;
    logic         w_reg_read;
    logic [5:0]   w_reg_addr;
    logic         regop_w_reg_rdy;
    logic [31:0]  regop_w_reg_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model_w [64];

    sha256_w_schedule dut (
        .clock            (clock),
        .reset            (reset),
        .local_go_sig     (local_go_sig),
        .pad_reg          (pad_reg),
        .w_reg_read       (w_reg_read),
        .w_reg_addr       (w_reg_addr),
        .regop_w_reg_rdy  (regop_w_reg_rdy),
        .regop_w_reg_data (regop_w_reg_data)
    );

    // ------------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One active edge, then settle 1ns; inputs change and outputs are sampled
    // at that point, well away from the next edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Checkers
    // ------------------------------------------------------------------------
    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model, straight from the SHA-256 message schedule definition
    // ------------------------------------------------------------------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        rotr = (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_model(input logic [511:0] blk);
        logic [31:0] s0;
        logic [31:0] s1;
        for (int i = 0; i < 16; i++) begin
            model_w[i] = blk[511 - 32*i -: 32];
        end
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(model_w[i-15], 7) ^ rotr(model_w[i-15], 18) ^ (model_w[i-15] >> 3);
            s1 = rotr(model_w[i-2], 17) ^ rotr(model_w[i-2], 19) ^ (model_w[i-2] >> 10);
            model_w[i] = s1 + model_w[i-7] + s0 + model_w[i-16];
        end
    endtask

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    task automatic read_word(input int addr, input logic [31:0] expv, input string tag);
        logic [31:0] e;
        exp_q.push_back(expv);
        w_reg_addr = addr[5:0];
        w_reg_read = 1'b1;
        step();
        w_reg_read = 1'b0;
        if (exp_q.size() == 0) begin
            check_int({tag, "_queue_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check32(tag, regop_w_reg_data, e);
        end
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 64; a++) begin
            read_word(a, model_w[a], $sformatf("%s_w%0d", tag, a));
        end
    endtask

    // Issue a one-cycle go pulse and measure edges from E0 until rdy is seen.
    task automatic start_and_time(input string tag, output int lat);
        local_go_sig = 1'b1;
        step();
        local_go_sig = 1'b0;
        check32({tag, "_rdy_after_e0"}, {31'b0, regop_w_reg_rdy}, 32'h0);
        lat = 0;
        while (!regop_w_reg_rdy && lat < 100) begin
            step();
            lat++;
        end
    endtask

    function automatic logic [511:0] random_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) begin
            b[32*i +: 32] = $urandom_range(32'hFFFF_FFFF, 0);
        end
        return b;
    endfunction

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        logic [511:0] abc_blk;
        logic [511:0] blk;
        int           lat;
        int           rises;
        int           drops;
        int           rise_at;
        logic         prev;
        int           k_addr [6];
        logic [31:0]  k_val  [6];

        k_addr = '{0, 15, 16, 17, 18, 63};
        k_val  = '{32'h61626380, 32'h00000018, 32'h61626380,
                   32'h000F0000, 32'h7DA86405, 32'h12B1EDEB};
        abc_blk = {32'h61626380, 448'h0, 32'h00000018};

        reset        = 1'b1;
        local_go_sig = 1'b0;
        pad_reg      = '0;
        w_reg_read   = 1'b0;
        w_reg_addr   = 6'd0;
        repeat (3) step();

        // Reset state
        check32("reset_rdy", {31'b0, regop_w_reg_rdy}, 32'h0);
        check32("reset_data", regop_w_reg_data, 32'h0);
        check32("reset_state", {30'b0, dut.state_dbg}, 32'h0);
        reset = 1'b0;
        step();

        // "abc" block
        pad_reg = abc_blk;
        build_model(abc_blk);
        start_and_time("abc", lat);
        check_int("abc_latency", lat, 49);
        for (int i = 0; i < 6; i++) begin
            read_word(k_addr[i], k_val[i], $sformatf("abc_const_w%0d", k_addr[i]));
        end
        read_all("abc");

        // All-zero block started from DONE, with a second go pulse mid-COMP
        pad_reg = '0;
        build_model('0);
        local_go_sig = 1'b1;
        step();
        local_go_sig = 1'b0;
        check32("zero_rdy_drop", {31'b0, regop_w_reg_rdy}, 32'h0);
        lat = 0;
        while (!regop_w_reg_rdy && lat < 100) begin
            local_go_sig = (lat == 21);
            step();
            lat++;
        end
        local_go_sig = 1'b0;
        check_int("zero_ignored_go_latency", lat, 49);
        read_all("zero");

        // Random block started from DONE
        blk = random_block();
        pad_reg = blk;
        build_model(blk);
        start_and_time("rand", lat);
        check_int("rand_latency", lat, 49);
        read_all("rand");

        // go held high for 200 cycles: exactly one computation
        blk = random_block();
        pad_reg = blk;
        build_model(blk);
        local_go_sig = 1'b1;
        step();
        check32("held_rdy_drop", {31'b0, regop_w_reg_rdy}, 32'h0);
        rises   = 0;
        drops   = 0;
        rise_at = -1;
        prev    = regop_w_reg_rdy;
        for (int k = 1; k < 200; k++) begin
            step();
            if (regop_w_reg_rdy && !prev) begin
                rises++;
                rise_at = k;
            end
            if (!regop_w_reg_rdy && prev) drops++;
            prev = regop_w_reg_rdy;
        end
        check_int("held_rises", rises, 1);
        check_int("held_rise_edge", rise_at, 49);
        check_int("held_drops", drops, 0);
        local_go_sig = 1'b0;
        step();
        check32("held_rdy_after_release", {31'b0, regop_w_reg_rdy}, 32'h1);
        read_all("held");

        // Reset during COMP, then recompute "abc"
        pad_reg = abc_blk;
        build_model(abc_blk);
        local_go_sig = 1'b1;
        step();                 // E0: start accepted
        local_go_sig = 1'b0;
        step();                 // E1: LOAD
        repeat (10) step();     // ten COMP cycles
        reset = 1'b1;
        step();
        check32("midreset_rdy", {31'b0, regop_w_reg_rdy}, 32'h0);
        check32("midreset_data", regop_w_reg_data, 32'h0);
        check32("midreset_state", {30'b0, dut.state_dbg}, 32'h0);
        reset = 1'b0;
        step();
        check32("midreset_state_idle_hold", {30'b0, dut.state_dbg}, 32'h0);
        start_and_time("reabc", lat);
        check_int("reabc_latency", lat, 49);
        read_all("reabc");

        check_int("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
